// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: decoded ID fields and control_unit feedback in,
// the hazard code and the stall counter out.
interface hazard_scoreboard_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_wreg;
  logic             id_regwe;
  logic             id_is_load;
  logic             pause_out;
  logic             flush;
  logic [1:0]       pause_in;
  logic [CNT_W-1:0] stall_cnt;

  // Handshake: no valid/ready pair. The ID fields are sampled on every cycle.
  // pause_in is combinational from those fields and registered state only.
  // pause_out and flush act only at the next rising edge.
  modport master (
    output id_rs, id_rt, id_wreg, id_regwe, id_is_load, pause_out, flush,
    input  pause_in, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_wreg, id_regwe, id_is_load, pause_out, flush,
    output pause_in, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker (EX..WB) producing the pause_in code for ID.
// Define HAZARD_FORWARD_EN to check only load-use in EX (ALU results forwarded).
module hazard_scoreboard #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 32
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave sb
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] load_q;
  logic [4:0]       reg_q [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic             ins_valid;
  logic             rs_hit;
  logic             rt_hit;
  logic             unused_ok;

  // A stalled or killed ID instruction enters the tracker as a bubble.
  assign ins_valid = !(sb.pause_out || sb.flush) && sb.id_regwe && (sb.id_wreg != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      load_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= 5'd0;
      end
      cnt_q <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        reg_q[i]   <= reg_q[i-1];
        load_q[i]  <= load_q[i-1];
      end
      valid_q[0] <= ins_valid;
      reg_q[0]   <= sb.id_wreg;
      load_q[0]  <= sb.id_is_load;
      if (sb.pause_out && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  // WB slot never qualifies: the register file writes before it is read.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
`ifdef HAZARD_FORWARD_EN
      if ((i == 0) && valid_q[i] && load_q[i]) begin
`else
      if (valid_q[i]) begin
`endif
        if ((sb.id_rs != 5'd0) && (reg_q[i] == sb.id_rs)) rs_hit = 1'b1;
        if ((sb.id_rt != 5'd0) && (reg_q[i] == sb.id_rt)) rt_hit = 1'b1;
      end
    end
  end

  assign sb.pause_in  = {rt_hit, rs_hit};
  assign sb.stall_cnt = cnt_q;
  assign unused_ok    = ^{load_q, valid_q[DEPTH-1], reg_q[DEPTH-1]};
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: main DUT at defaults plus a CNT_W=4
// instance for counter saturation.
module tb_hazard_scoreboard;
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hazard_scoreboard_if #(.CNT_W(32)) m ();
  hazard_scoreboard_if #(.CNT_W(4))  s ();

  hazard_scoreboard #(.DEPTH(3), .CNT_W(32)) dut (.clk(clk), .rst(rst), .sb(m.slave));
  hazard_scoreboard #(.DEPTH(3), .CNT_W(4))  dut_sat (.clk(clk), .rst(rst), .sb(s.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: rs, rt, wreg, regwe, is_load, pause_out, flush
  task automatic id_drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wreg,
                          input logic regwe, input logic ld, input logic pout, input logic fl);
    m.id_rs      = rs;
    m.id_rt      = rt;
    m.id_wreg    = wreg;
    m.id_regwe   = regwe;
    m.id_is_load = ld;
    m.pause_out  = pout;
    m.flush      = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      id_drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    s.id_rs = 5'd0; s.id_rt = 5'd0; s.id_wreg = 5'd0;
    s.id_regwe = 1'b0; s.id_is_load = 1'b0; s.pause_out = 1'b0; s.flush = 1'b0;
    id_drive(5'd3, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("reset_pause_in", {30'd0, m.pause_in}, 32'd0);
    chk("reset_cnt", m.stall_cnt, 32'd0);
    chk("reset_cnt_sat", {28'd0, s.stall_cnt}, 32'd0);
    rst = 1'b0;

    // addi $3 then add $4,$3,$1: two stall cycles
    id_drive(5'd0, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("addi3_free", {30'd0, m.pause_in}, 32'd0);
    tick();
    id_drive(5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("raw_rs_ex", {30'd0, m.pause_in}, 32'd1);
    tick();
    id_drive(5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("raw_rs_mem", {30'd0, m.pause_in}, 32'd1);
    tick();
    id_drive(5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("raw_rs_wb_release", {30'd0, m.pause_in}, 32'd0);
    chk("cnt_after_raw", m.stall_cnt, 32'd2);
    tick();
    drain();

    // writer $7 then sw $7 (rt side)
    id_drive(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    id_drive(5'd2, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sw_rt_ex", {30'd0, m.pause_in}, 32'd2);
    tick();
    id_drive(5'd2, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sw_rt_mem", {30'd0, m.pause_in}, 32'd2);
    tick();
    id_drive(5'd2, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sw_release", {30'd0, m.pause_in}, 32'd0);
    tick();

    // writer $7, one-instruction gap, add $8,$7,$7: both sides, one cycle
    id_drive(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    id_drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    id_drive(5'd7, 5'd7, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("gap_both_mem", {30'd0, m.pause_in}, 32'd3);
    tick();
    id_drive(5'd7, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("gap_release", {30'd0, m.pause_in}, 32'd0);
    chk("cnt_after_gap", m.stall_cnt, 32'd5);
    tick();

    // writer of $0, then reader of $0; then $8 reaches WB
    id_drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    id_drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("zero_reg_no_hit", {30'd0, m.pause_in}, 32'd0);
    tick();
    id_drive(5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wb_slot_ignored", {30'd0, m.pause_in}, 32'd0);
    chk("cnt_zero_reg", m.stall_cnt, 32'd5);
    tick();

    // flushed writer of $9 leaves no trace
    id_drive(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    id_drive(5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_no_stall", {30'd0, m.pause_in}, 32'd0);
    tick();
    drain();

    // lw $5 then add $6,$5,$1
    id_drive(5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    id_drive(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("load_use_ex", {30'd0, m.pause_in}, 32'd1);
    tick();
    id_drive(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, !FWD, 1'b0);
    chk("load_use_mem", {30'd0, m.pause_in}, FWD ? 32'd0 : 32'd1);
    tick();
    id_drive(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("load_use_done", {30'd0, m.pause_in}, 32'd0);
    chk("cnt_load_use", m.stall_cnt, FWD ? 32'd6 : 32'd7);
    tick();
    drain();

    // addi $5 then add $6,$5,$1
    id_drive(5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    id_drive(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("alu_use", {30'd0, m.pause_in}, FWD ? 32'd0 : 32'd1);
    tick();
    drain();

    // reset asserted during the second stall cycle
    id_drive(5'd0, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    id_drive(5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_stall1", {30'd0, m.pause_in}, FWD ? 32'd0 : 32'd1);
    tick();
    rst = 1'b1;
    id_drive(5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    id_drive(5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_pause_in", {30'd0, m.pause_in}, 32'd0);
    chk("post_rst_cnt", m.stall_cnt, 32'd0);
    tick();

    // saturation on the 4-bit counter
    s.pause_out = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_cnt_14", {28'd0, s.stall_cnt}, 32'd14);
    tick();
    chk("sat_cnt_15", {28'd0, s.stall_cnt}, 32'd15);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_cnt_hold", {28'd0, s.stall_cnt}, 32'd15);
    chk("sat_pause_in", {30'd0, s.pause_in}, 32'd0);
    s.pause_out = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
